// File: rtl/pwm_burst_array.sv
// Multi-channel phased PWM burst generator: on start, every channel emits N periods
// after its own phase delay. Optional abort input is enabled by PWM_BURST_ABORT_EN.

module pwm_burst_chan #(
  parameter int PERIOD = 2500,
  parameter int OW     = 12,
  parameter int DW     = 12,
  parameter int PCW    = 8
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           clr_i,
  input  logic [OW-1:0]  off_i,
  input  logic [PCW-1:0] num_i,
  input  logic [DW-1:0]  duty_i,
  output logic           sig_o,
  output logic           fin_o
);
  localparam logic [OW-1:0] PMAX = OW'(PERIOD - 1);

  logic [OW-1:0]  delay_q, delay_d;
  logic [OW-1:0]  phase_q, phase_d;
  logic [PCW-1:0] rem_q, rem_d;
  logic [DW-1:0]  duty_q, duty_d;
  logic           sig_q, sig_d;

  always_comb begin
    delay_d = delay_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    duty_d  = duty_q;
    if (load_i) begin
      delay_d = (off_i > PMAX) ? PMAX : off_i;
      phase_d = '0;
      rem_d   = num_i;
      duty_d  = duty_i;
    end else if (clr_i) begin
      delay_d = '0;
      phase_d = '0;
      rem_d   = '0;
    end else if (step_i) begin
      if (delay_q != '0) begin
        delay_d = delay_q - OW'(1);
      end else if (rem_q != '0) begin
        if (phase_q == PMAX) begin
          phase_d = '0;
          rem_d   = rem_q - PCW'(1);
        end else begin
          phase_d = phase_q + OW'(1);
        end
      end
    end
    // Output is decoded from next state so sig_o is a plain register.
    sig_d = (delay_d == '0) && (rem_d != '0) && (DW'(phase_d) < duty_d);
    fin_o = (delay_d == '0) && (rem_d == '0);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      delay_q <= '0;
      phase_q <= '0;
      rem_q   <= '0;
      duty_q  <= '0;
      sig_q   <= 1'b0;
    end else begin
      delay_q <= delay_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      duty_q  <= duty_d;
      sig_q   <= sig_d;
    end
  end

  assign sig_o = sig_q;
endmodule

module pwm_burst_array #(
  parameter int NUM_CHANNELS           = 4,
  parameter int PERIOD_IN_CLOCK_CYCLES = 2500,
  parameter int PULSE_COUNT_WIDTH      = 8
) (
  input  logic                                                clk_in,
  input  logic                                                rst_in,
`ifdef PWM_BURST_ABORT_EN
  input  logic                                                abort_in,
`endif
  input  logic                                                start_in,
  input  logic [PULSE_COUNT_WIDTH-1:0]                        num_pulses_in,
  input  logic [$clog2(PERIOD_IN_CLOCK_CYCLES+1)-1:0]         duty_in,
  input  logic [NUM_CHANNELS*$clog2(PERIOD_IN_CLOCK_CYCLES)-1:0] phase_offsets_in,
  output logic [NUM_CHANNELS-1:0]                             sig_out,
  output logic                                                busy_out,
  output logic                                                done_out
);
  localparam int DW = $clog2(PERIOD_IN_CLOCK_CYCLES + 1);
  localparam int OW = $clog2(PERIOD_IN_CLOCK_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  state_q;
  logic                    busy_q, done_q;
  logic                    abort_w, accept_w, step_w, clr_w, all_fin_w;
  logic [NUM_CHANNELS-1:0] fin_w;

`ifdef PWM_BURST_ABORT_EN
  assign abort_w = abort_in;
`else
  assign abort_w = 1'b0;
`endif

  assign accept_w  = (state_q == S_IDLE) && start_in;
  assign step_w    = (state_q == S_RUN);
  assign clr_w     = (state_q == S_RUN) && abort_w;
  assign all_fin_w = &fin_w;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      pwm_burst_chan #(
        .PERIOD (PERIOD_IN_CLOCK_CYCLES),
        .OW     (OW),
        .DW     (DW),
        .PCW    (PULSE_COUNT_WIDTH)
      ) u_ch (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .load_i (accept_w),
        .step_i (step_w),
        .clr_i  (clr_w),
        .off_i  (phase_offsets_in[gi*OW +: OW]),
        .num_i  (num_pulses_in),
        .duty_i (duty_in),
        .sig_o  (sig_out[gi]),
        .fin_o  (fin_w[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start_in) begin
          if (num_pulses_in != '0) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        // all_fin_w looks at next-cycle channel state, so the last RUN cycle is exact.
        S_RUN: if (abort_w || all_fin_w) begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        S_DONE: state_q <= S_IDLE;
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_out = busy_q;
  assign done_out = done_q;
endmodule

// File: tb/tb_pwm_burst_array.sv
// Scoreboarded random/directed bench for pwm_burst_array against a time-based burst model.
module tb_pwm_burst_array;
  localparam int NC  = 4;
  localparam int P   = 10;
  localparam int PCW = 8;
  localparam int DW  = $clog2(P + 1);
  localparam int OW  = $clog2(P);

  logic               clk_in = 1'b0;
  logic               rst_in, start_in;
  logic [PCW-1:0]     num_pulses_in;
  logic [DW-1:0]      duty_in;
  logic [NC*OW-1:0]   phase_offsets_in;
  logic [NC-1:0]      sig_out;
  logic               busy_out, done_out;
`ifdef PWM_BURST_ABORT_EN
  logic               abort_in = 1'b0;
`endif

  always #5 clk_in = ~clk_in;

  pwm_burst_array #(
    .NUM_CHANNELS           (NC),
    .PERIOD_IN_CLOCK_CYCLES (P),
    .PULSE_COUNT_WIDTH      (PCW)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
`ifdef PWM_BURST_ABORT_EN
    .abort_in         (abort_in),
`endif
    .start_in         (start_in),
    .num_pulses_in    (num_pulses_in),
    .duty_in          (duty_in),
    .phase_offsets_in (phase_offsets_in),
    .sig_out          (sig_out),
    .busy_out         (busy_out),
    .done_out         (done_out)
  );

  typedef struct packed {
    logic [NC-1:0] sig;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc    = 0;

  // Reference model: 0 idle, 1 run, 2 done; m_t is burst time within RUN.
  int m_st = 0, m_t = 0, m_n = 0, m_duty = 0, m_len = 0;
  int m_off[NC];

  function automatic logic [NC*OW-1:0] pack(input int o0, input int o1, input int o2, input int o3);
    logic [NC*OW-1:0] v;
    v = '0;
    v[0*OW +: OW] = OW'(o0);
    v[1*OW +: OW] = OW'(o1);
    v[2*OW +: OW] = OW'(o2);
    v[3*OW +: OW] = OW'(o3);
    return v;
  endfunction

  task automatic step(input logic rst, input logic st, input logic ab);
    exp_t e;
    logic ab_eff;
`ifdef PWM_BURST_ABORT_EN
    abort_in = ab;
    ab_eff   = ab;
`else
    ab_eff   = 1'b0 & ab;
`endif
    rst_in   = rst;
    start_in = st;
    if (rst) m_st = 0;
    else case (m_st)
      0: if (st) begin
        m_n = int'(num_pulses_in);
        m_duty = int'(duty_in);
        m_len = 0;
        for (int i = 0; i < NC; i++) begin
          int o;
          o = int'(phase_offsets_in[i*OW +: OW]);
          m_off[i] = (o > P - 1) ? P - 1 : o;
          if (m_off[i] > m_len) m_len = m_off[i];
        end
        m_len += m_n * P;
        m_t = 0;
        m_st = (m_n == 0) ? 2 : 1;
      end
      1: if (ab_eff) m_st = 2;
         else begin
           m_t++;
           if (m_t == m_len) m_st = 2;
         end
      default: m_st = 0;
    endcase
    e.busy = (m_st == 1);
    e.done = (m_st == 2);
    e.sig  = '0;
    if (m_st == 1)
      for (int i = 0; i < NC; i++)
        if (m_t >= m_off[i] && m_t < m_off[i] + m_n * P)
          e.sig[i] = (((m_t - m_off[i]) % P) < m_duty);
    @(posedge clk_in);
    q.push_back(e);
    #1;
    cyc++;
  endtask

  task automatic rand_inputs();
    num_pulses_in    = PCW'($urandom_range(0, 4));
    duty_in          = DW'($urandom_range(0, 12));
    phase_offsets_in = NC*OW'($urandom);
  endtask

  // Issue a start, then follow the burst; rst/start/abort may be injected at RUN cycle k.
  task automatic burst(input int n, input int d, input logic [NC*OW-1:0] offs,
                       input int rst_at, input int ab_at, input int st_at, input bit scramble);
    int k;
    num_pulses_in    = PCW'(n);
    duty_in          = DW'(d);
    phase_offsets_in = offs;
    step(1'b0, 1'b1, 1'b0);
    k = 0;
    while (m_st != 0 && k < 200) begin
      if (scramble) rand_inputs();
      step(k == rst_at, k == st_at, k == ab_at);
      k++;
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    forever begin
      @(negedge clk_in);
      if (q.size() > 0) begin
        me = q.pop_front();
        n_chk++;
        if ({sig_out, busy_out, done_out} === me) n_pass++;
        else $display("FAIL outputs cyc%0d: got sig=%b busy=%b done=%b, expected sig=%b busy=%b done=%b",
                      cyc, sig_out, busy_out, done_out, me.sig, me.busy, me.done);
      end
    end
  end

  initial begin
    rst_in = 1'b1; start_in = 1'b0;
    num_pulses_in = '0; duty_in = '0; phase_offsets_in = '0;
    repeat (3) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    burst(3, 5,  pack(0, 0, 0, 0), -1, -1, -1, 1'b0);
    burst(2, 3,  pack(0, 4, 0, 4), -1, -1, -1, 1'b1);
    burst(0, 5,  pack(1, 2, 3, 4), -1, -1, -1, 1'b0);
    burst(3, 5,  pack(0, 0, 0, 0), -1, -1, 10, 1'b1);
    burst(2, 0,  pack(0, 1, 2, 3), -1, -1, -1, 1'b0);
    burst(2, 10, pack(0, 5, 9, 3), -1, -1, -1, 1'b0);
    burst(2, 12, pack(15, 0, 3, 9), -1, -1, -1, 1'b0);
    burst(1, 4,  pack(15, 14, 10, 9), -1, -1, -1, 1'b0);
    burst(3, 5,  pack(0, 0, 0, 0), 7, -1, -1, 1'b0);
    burst(3, 5,  pack(0, 0, 0, 0), -1, -1, -1, 1'b0);
    burst(3, 5,  pack(0, 0, 0, 0), -1, 12, -1, 1'b0);
    for (int r = 0; r < 40; r++) begin
      int n, d, ra, aa, sa;
      n  = $urandom_range(0, 4);
      d  = $urandom_range(0, 12);
      ra = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 30) : -1;
      aa = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 30) : -1;
      sa = $urandom_range(0, 40);
      burst(n, d, NC*OW'($urandom), ra, aa, sa, 1'b1);
    end
    @(negedge clk_in);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pwm_burst_array.md
Name: pwm_burst_array

Overview:
Multi-channel phased PWM burst generator for the ultrasonic transmit array; the generalised successor of the single-channel free-running PWM.
- On a start pulse, each channel emits exactly N pulse periods of programmable duty, delayed by a per-channel phase offset, for beam steering.
- Sits between the steering-angle/delay calculator and the transducer drivers; reports busy/done to the sonar sequencer so the receive window can open.

Parameters:
NUM_CHANNELS, 4, number of transducer outputs
PERIOD_IN_CLOCK_CYCLES, 2500, pulse period in clk_in cycles (40 kHz at 100 MHz); must be >= 2
PULSE_COUNT_WIDTH, 8, width of the burst-length field

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
start_in  input  1  one-cycle burst request; sampled only in IDLE
num_pulses_in  input  PULSE_COUNT_WIDTH  periods per channel; latched on accepted start
duty_in  input  DW=$clog2(PERIOD_IN_CLOCK_CYCLES+1)  high cycles per period; latched on start
phase_offsets_in  input  NUM_CHANNELS*OW, OW=$clog2(PERIOD_IN_CLOCK_CYCLES)  channel i delay in bits [i*OW +: OW]; latched on start
sig_out  output  NUM_CHANNELS  per-channel drive
busy_out  output  1  high from the cycle after an accepted start until the burst completes
done_out  output  1  one-cycle completion pulse

Behaviour:
- One clock domain (clk_in); reset is synchronous and active-high on rst_in. Reset: state IDLE, sig_out=0, busy_out=0, done_out=0, all counters 0. Reset mid-burst terminates at once with no done_out.
- States: IDLE -> RUN on start_in with num_pulses_in != 0; IDLE -> DONE on start_in with num_pulses_in == 0; RUN -> DONE when every channel has finished; DONE -> IDLE unconditionally after 1 cycle.
- Latching: num_pulses, duty and offsets are registered on the accepted start edge. Input changes during RUN have no effect.
- Burst time t: t=0 in the first RUN cycle and increments each cycle.
- Channel i is active for offset_i <= t < offset_i + N*PERIOD.
  - While active: sig_out[i] = ((t - offset_i) mod PERIOD) < duty.
  - Otherwise: sig_out[i] = 0.
- Implementation: per-channel delay countdown, phase counter (0..PERIOD-1, wraps to 0) and pulse counter. No arithmetic modulo; counters only.
- Offsets >= PERIOD are clamped to PERIOD-1. duty >= PERIOD gives a constant high while active. duty = 0 gives a constant low.
- sig_out is driven from registered state only; no combinational path from any input.
- RUN length is max(offset_i) + N*PERIOD cycles.
- In DONE: busy_out=0 and done_out=1 for exactly one cycle.
- start_in while RUN or DONE is ignored, not queued.
- Simultaneous rst_in and start_in: reset wins.

Optional Feature:
PWM_BURST_ABORT_EN
- Defined: adds input abort_in (1 bit).
  - In RUN, abort_in forces sig_out=0 the next cycle and enters DONE; done_out pulses as normal.
  - abort_in in IDLE or DONE is ignored.
  - Simultaneous start_in and abort_in in IDLE: start accepted.
- Undefined: port absent; a burst always runs to completion.

Test Plan:
1. PERIOD=10, 2 channels, N=3, duty=5, offsets {0,0}, start -> both outputs high 5 / low 5 for 3 periods (30 RUN cycles); done_out at RUN cycle 30; busy_out high exactly 30 cycles.
2. Offsets {0,4}, N=2, duty=3 -> ch1 rises 4 cycles after ch0; ch0 ends after 20 cycles, ch1 after 24; RUN lasts 24 cycles; done_out pulses once.
3. N=0 -> no sig_out activity; done_out one cycle after start; busy_out stays 0. Second start pulse during a running burst -> ignored, and the burst length is unchanged.
4. duty=0 -> sig_out constant 0 for N*PERIOD. duty=10 or 12 -> constant 1 while active. Offset 15 -> treated as 9.
5. rst_in asserted at RUN cycle 7 -> next cycle sig_out=0, busy_out=0, no done_out; a fresh start then behaves as in test 1.
6. (PWM_BURST_ABORT_EN) abort_in at RUN cycle 12 of test 1 -> sig_out 0 at cycle 13, done_out one cycle, return to IDLE.
